// File: rtl/vector_exec_unit.sv
// Vector execution unit: an internal els_p x vlen_p register file with lane-parallel
// add/sub/mul (vector or scalar operand), read-out, write and reduce-sum.
module vector_exec_unit #(
    parameter int els_p   = 8,
    parameter int vlen_p  = 8,
    parameter int vdw_p   = 8,
    parameter int lanes_p = 4,
    parameter int sat_p   = 0
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       v_i,
    output logic                       ready_o,
    input  logic [3:0]                 op_i,
    input  logic [$clog2(els_p)-1:0]   addrA_i,
    input  logic [$clog2(els_p)-1:0]   addrB_i,
    input  logic [$clog2(els_p)-1:0]   addrD_i,
    input  logic [vdw_p-1:0]           scalar_i,
    input  logic [vlen_p*vdw_p-1:0]    w_data_i,
    output logic [vlen_p*vdw_p-1:0]    r_data_o,
    output logic                       v_o,
    input  logic                       yumi_i,
    output logic                       done_o,
    output logic                       err_o
);
    localparam int aw       = $clog2(els_p);
    localparam int nbeats   = vlen_p / lanes_p;
    localparam int bw       = (nbeats > 1) ? $clog2(nbeats) : 1;
    localparam int iw       = (vlen_p > 1) ? $clog2(vlen_p) : 1;
    localparam int pw       = 2 * vdw_p + 1;
    localparam int dw       = vlen_p * vdw_p;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_MUL  = 4'b0010;
    localparam logic [3:0] OP_ADDS = 4'b0100;
    localparam logic [3:0] OP_SUBS = 4'b0101;
    localparam logic [3:0] OP_MULS = 4'b0110;
    localparam logic [3:0] OP_RD   = 4'b1000;
    localparam logic [3:0] OP_WR   = 4'b1001;
    localparam logic [3:0] OP_RED  = 4'b1010;

    localparam logic signed [pw-1:0] max_v = {{(pw-vdw_p+1){1'b0}}, {(vdw_p-1){1'b1}}};
    localparam logic signed [pw-1:0] min_v = {{(pw-vdw_p+1){1'b1}}, {(vdw_p-1){1'b0}}};

    if (vlen_p % lanes_p != 0) begin : g_bad_lanes
        $error("vector_exec_unit: vlen_p must be a multiple of lanes_p");
    end

    typedef enum logic [1:0] {IDLE, EXEC, DONE, RESP} state_e;
    state_e state_r, state_n;

    logic [3:0]       op_r;
    logic [aw-1:0]    addr_a_r, addr_b_r, addr_d_r;
    logic [vdw_p-1:0] scalar_r;
    logic [dw-1:0]    wdata_r;
    logic [bw-1:0]    beat_r;
    logic [vdw_p-1:0] acc_r;
    logic [dw-1:0]    rbuf_r;
    logic [vdw_p-1:0] rf [els_p][vlen_p];

    logic [iw-1:0]    lane_idx [lanes_p];
    logic [vdw_p-1:0] a_el     [lanes_p];
    logic [vdw_p-1:0] b_el     [lanes_p];
    logic [vdw_p-1:0] res      [lanes_p];
    logic [vdw_p-1:0] acc_n;
    logic             last_beat;

    function automatic logic is_legal(input logic [3:0] op);
        return op inside {OP_ADD, OP_SUB, OP_MUL, OP_ADDS, OP_SUBS, OP_MULS, OP_RD, OP_WR, OP_RED};
    endfunction

    function automatic logic is_write(input logic [3:0] op);
        return op inside {OP_ADD, OP_SUB, OP_MUL, OP_ADDS, OP_SUBS, OP_MULS, OP_WR};
    endfunction

    function automatic logic signed [pw-1:0] sext(input logic [vdw_p-1:0] x);
        return {{(pw-vdw_p){x[vdw_p-1]}}, x};
    endfunction

    // Wide intermediate is exact for add/sub/mul, so clamping or truncating it is enough.
    function automatic logic [vdw_p-1:0] fit(input logic signed [pw-1:0] x);
        if (sat_p != 0 && x > max_v) return max_v[vdw_p-1:0];
        if (sat_p != 0 && x < min_v) return min_v[vdw_p-1:0];
        return x[vdw_p-1:0];
    endfunction

    assign last_beat = (beat_r == bw'(nbeats - 1));

    // Lane datapath: each beat touches only its own element slots, so D may alias A or B.
    always_comb begin
        acc_n = acc_r;
        for (int l = 0; l < lanes_p; l++) begin
            lane_idx[l] = iw'(int'(beat_r) * lanes_p + l);
            a_el[l]     = rf[addr_a_r][lane_idx[l]];
            b_el[l]     = op_r[2] ? scalar_r : rf[addr_b_r][lane_idx[l]];
            case (op_r)
                OP_ADD, OP_ADDS: res[l] = fit(sext(a_el[l]) + sext(b_el[l]));
                OP_SUB, OP_SUBS: res[l] = fit(sext(a_el[l]) - sext(b_el[l]));
                OP_MUL, OP_MULS: res[l] = fit(sext(a_el[l]) * sext(b_el[l]));
                OP_WR:           res[l] = wdata_r[lane_idx[l]*vdw_p +: vdw_p];
                default:         res[l] = a_el[l];
            endcase
            acc_n = fit(sext(acc_n) + sext(a_el[l]));
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) state_r <= IDLE;
        else         state_r <= state_n;
    end

    always_comb begin
        state_n  = state_r;
        ready_o  = 1'b0;
        v_o      = 1'b0;
        done_o   = 1'b0;
        err_o    = 1'b0;
        r_data_o = '0;
        case (state_r)
            IDLE: begin
                ready_o = 1'b1;
                if (v_i) state_n = is_legal(op_i) ? EXEC : DONE;
            end
            EXEC: begin
                if (last_beat) state_n = (op_r == OP_RD || op_r == OP_RED) ? RESP : DONE;
            end
            DONE: begin
                done_o  = 1'b1;
                err_o   = ~is_legal(op_r);
                state_n = IDLE;
            end
            RESP: begin
                v_o      = 1'b1;
                r_data_o = rbuf_r;
                if (yumi_i) begin
                    done_o  = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            op_r     <= '0;
            addr_a_r <= '0;
            addr_b_r <= '0;
            addr_d_r <= '0;
            scalar_r <= '0;
            wdata_r  <= '0;
            beat_r   <= '0;
            acc_r    <= '0;
            rbuf_r   <= '0;
            for (int i = 0; i < els_p; i++)
                for (int j = 0; j < vlen_p; j++)
                    rf[i][j] <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (v_i) begin
                        op_r     <= op_i;
                        addr_a_r <= addrA_i;
                        addr_b_r <= addrB_i;
                        addr_d_r <= addrD_i;
                        scalar_r <= scalar_i;
                        wdata_r  <= w_data_i;
                        beat_r   <= '0;
                        acc_r    <= '0;
                        rbuf_r   <= '0;
                    end
                end
                EXEC: begin
                    for (int l = 0; l < lanes_p; l++) begin
                        if (is_write(op_r)) rf[addr_d_r][lane_idx[l]] <= res[l];
                        if (op_r == OP_RD)  rbuf_r[lane_idx[l]*vdw_p +: vdw_p] <= a_el[l];
                    end
                    acc_r  <= acc_n;
                    beat_r <= last_beat ? '0 : beat_r + 1'b1;
                    if (op_r == OP_RED && last_beat) rbuf_r <= {{(dw-vdw_p){1'b0}}, acc_n};
                end
                RESP: begin
                    if (yumi_i) rbuf_r <= '0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_vector_exec_unit.sv
// Directed bench for vector_exec_unit: a wrap-mode and a saturate-mode instance share
// stimulus; responses are checked by a monitor against per-instance expected queues.
module tb_vector_exec_unit;
    logic        clk_i = 1'b0;
    logic        reset_i, v_i, yumi_i;
    logic [3:0]  op_i;
    logic [2:0]  addr_a, addr_b, addr_d;
    logic [7:0]  scalar_i;
    logic [63:0] w_data_i;

    logic        ready_w, v_o_w, done_w, err_w;
    logic        ready_s, v_o_s, done_s, err_s;
    logic [63:0] rdata_w, rdata_s;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_w_q[$];
    logic [63:0] exp_s_q[$];
    logic [63:0] mem_w[8];
    logic [63:0] mem_s[8];

    vector_exec_unit #(.els_p(8), .vlen_p(8), .vdw_p(8), .lanes_p(4), .sat_p(0)) dut_w (
        .clk_i(clk_i), .reset_i(reset_i), .v_i(v_i), .ready_o(ready_w), .op_i(op_i),
        .addrA_i(addr_a), .addrB_i(addr_b), .addrD_i(addr_d), .scalar_i(scalar_i),
        .w_data_i(w_data_i), .r_data_o(rdata_w), .v_o(v_o_w), .yumi_i(yumi_i),
        .done_o(done_w), .err_o(err_w)
    );

    vector_exec_unit #(.els_p(8), .vlen_p(8), .vdw_p(8), .lanes_p(4), .sat_p(1)) dut_s (
        .clk_i(clk_i), .reset_i(reset_i), .v_i(v_i), .ready_o(ready_s), .op_i(op_i),
        .addrA_i(addr_a), .addrB_i(addr_b), .addrD_i(addr_d), .scalar_i(scalar_i),
        .w_data_i(w_data_i), .r_data_o(rdata_s), .v_o(v_o_s), .yumi_i(yumi_i),
        .done_o(done_s), .err_o(err_s)
    );

    // clock / watchdog
    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] fill(input logic [7:0] x);
        return {8{x}};
    endfunction

    function automatic logic [63:0] ramp(input int start, input int step);
        logic [63:0] v;
        for (int k = 0; k < 8; k++) v[k*8 +: 8] = 8'(start + k * step);
        return v;
    endfunction

    // scoreboard monitor: pops on every consumed response
    always @(negedge clk_i) begin
        if (v_o_w && yumi_i) begin
            if (exp_w_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL resp_w: got unexpected response %h required none", rdata_w);
            end else check("resp_w", rdata_w, exp_w_q.pop_front());
        end
        if (v_o_s && yumi_i) begin
            if (exp_s_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL resp_s: got unexpected response %h required none", rdata_s);
            end else check("resp_s", rdata_s, exp_s_q.pop_front());
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic issue(input logic [3:0] op, input int a, input int b, input int d,
                         input logic [7:0] s, input logic [63:0] wd);
        int n = 0;
        while (!ready_w && n < 50) begin tick(); n++; end
        check("issue_ready", {63'b0, ready_w}, 64'd1);
        op_i = op; addr_a = 3'(a); addr_b = 3'(b); addr_d = 3'(d);
        scalar_i = s; w_data_i = wd; v_i = 1'b1;
        tick();
        v_i = 1'b0;
    endtask

    task automatic wait_done(input string name, input int exp_lat, input logic exp_err);
        int lat = 0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk_i);
            if (done_w) begin
                lat = n;
                check({name, "_err_w"}, {63'b0, err_w}, {63'b0, exp_err});
                check({name, "_err_s"}, {63'b0, err_s}, {63'b0, exp_err});
                check({name, "_done_s"}, {63'b0, done_s}, 64'd1);
                break;
            end
        end
        check({name, "_done_lat"}, 64'(lat), 64'(exp_lat));
        @(negedge clk_i);
        check({name, "_ready_after"}, {62'b0, ready_w, ready_s}, 64'b11);
        check({name, "_done_pulse"}, {62'b0, done_w, done_s}, 64'b0);
    endtask

    task automatic do_op(input string name, input logic [3:0] op, input int a, input int b,
                         input int d, input logic [7:0] s, input logic [63:0] wd,
                         input int lat, input logic err);
        issue(op, a, b, d, s, wd);
        wait_done(name, lat, err);
    endtask

    task automatic write_vec(input int d, input logic [63:0] data);
        do_op("write", 4'b1001, 0, 0, d, 8'h00, data, 3, 1'b0);
        mem_w[d] = data;
        mem_s[d] = data;
    endtask

    task automatic do_read(input string name, input logic [3:0] op, input int a,
                           input logic [63:0] ew, input logic [63:0] es, input int hold);
        int lat = 0;
        exp_w_q.push_back(ew);
        exp_s_q.push_back(es);
        issue(op, a, 0, 0, 8'h00, 64'h0);
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk_i);
            if (v_o_w) begin lat = n; break; end
        end
        check({name, "_v_lat"}, 64'(lat), 64'd3);
        for (int h = 0; h <= hold; h++) begin
            check({name, "_v_hold"}, {62'b0, v_o_w, v_o_s}, 64'b11);
            check({name, "_data_hold_w"}, rdata_w, ew);
            check({name, "_data_hold_s"}, rdata_s, es);
            check({name, "_no_done"}, {62'b0, done_w, done_s}, 64'b0);
            if (h < hold) @(negedge clk_i);
        end
        @(posedge clk_i);
        #1 yumi_i = 1'b1;
        @(negedge clk_i);
        check({name, "_done_on_yumi"}, {62'b0, done_w, done_s}, 64'b11);
        tick();
        yumi_i = 1'b0;
        @(negedge clk_i);
        check({name, "_after_done"}, {62'b0, done_w, done_s}, 64'b0);
        check({name, "_after_v"}, {62'b0, v_o_w, v_o_s}, 64'b0);
        check({name, "_after_ready"}, {62'b0, ready_w, ready_s}, 64'b11);
        check({name, "_after_rdata"}, rdata_w | rdata_s, 64'h0);
    endtask

    task automatic read_all(input string name);
        for (int i = 0; i < 8; i++) do_read(name, 4'b1000, i, mem_w[i], mem_s[i], 0);
    endtask

    initial begin
        reset_i = 1'b1; v_i = 1'b0; yumi_i = 1'b0; op_i = '0;
        addr_a = '0; addr_b = '0; addr_d = '0; scalar_i = '0; w_data_i = '0;
        for (int i = 0; i < 8; i++) begin mem_w[i] = '0; mem_s[i] = '0; end
        repeat (3) tick();
        reset_i = 1'b0;
        @(negedge clk_i);
        check("rst_ready", {62'b0, ready_w, ready_s}, 64'b11);
        check("rst_v", {62'b0, v_o_w, v_o_s}, 64'b0);
        check("rst_done_err", {60'b0, done_w, done_s, err_w, err_s}, 64'b0);
        check("rst_rdata", rdata_w | rdata_s, 64'h0);

        // basic add with timing
        write_vec(0, ramp(1, 1));
        write_vec(1, fill(8'd10));
        do_op("add", 4'b0000, 0, 1, 2, 8'h00, 64'h0, 3, 1'b0);
        mem_w[2] = ramp(11, 1); mem_s[2] = ramp(11, 1);
        do_read("rd_v2", 4'b1000, 2, mem_w[2], mem_s[2], 0);

        // overflowing add: wrap -56, saturate 127
        write_vec(0, fill(8'd100));
        do_op("add_ovf", 4'b0000, 0, 0, 3, 8'h00, 64'h0, 3, 1'b0);
        mem_w[3] = fill(8'hC8); mem_s[3] = fill(8'h7F);
        do_read("rd_v3", 4'b1000, 3, mem_w[3], mem_s[3], 0);

        // subtract with D aliasing A: -56-10=-66, 127-10=117
        do_op("sub_alias", 4'b0001, 3, 1, 3, 8'h00, 64'h0, 3, 1'b0);
        mem_w[3] = fill(8'hBE); mem_s[3] = fill(8'h75);
        do_read("rd_v3b", 4'b1000, 3, mem_w[3], mem_s[3], 0);

        // vector multiply: 10*10=100, then 100*100 -> wrap 16, saturate 127
        do_op("mul", 4'b0010, 1, 1, 5, 8'h00, 64'h0, 3, 1'b0);
        do_op("mul_ovf", 4'b0010, 5, 5, 5, 8'h00, 64'h0, 3, 1'b0);
        mem_w[5] = fill(8'h10); mem_s[5] = fill(8'h7F);
        do_read("rd_v5", 4'b1000, 5, mem_w[5], mem_s[5], 0);

        // scalar ops: 10-(-128)=138 -> wrap -118, saturate 127; 10+5=15
        do_op("subs", 4'b0101, 1, 0, 6, 8'h80, 64'h0, 3, 1'b0);
        mem_w[6] = fill(8'h8A); mem_s[6] = fill(8'h7F);
        do_read("rd_v6", 4'b1000, 6, mem_w[6], mem_s[6], 0);
        do_op("adds", 4'b0100, 1, 0, 7, 8'h05, 64'h0, 3, 1'b0);
        mem_w[7] = fill(8'd15); mem_s[7] = fill(8'd15);
        do_read("rd_v7", 4'b1000, 7, mem_w[7], mem_s[7], 0);

        // reduce-sum: 8*100=800 -> wrap 32, saturate 127; then 1..8 = 36
        do_read("red_ovf", 4'b1010, 0, 64'h20, 64'h7F, 0);
        write_vec(0, ramp(1, 1));
        do_read("red", 4'b1010, 0, 64'h24, 64'h24, 0);

        // scalar multiply by -3
        do_op("muls", 4'b0110, 0, 0, 4, 8'hFD, 64'h0, 3, 1'b0);
        mem_w[4] = ramp(-3, -3); mem_s[4] = ramp(-3, -3);
        do_read("rd_v4", 4'b1000, 4, mem_w[4], mem_s[4], 0);

        // response back-pressure
        do_read("rd_hold", 4'b1000, 1, fill(8'd10), fill(8'd10), 5);

        // illegal opcode: immediate done+err, no state change
        do_op("illegal", 4'b0111, 0, 1, 2, 8'h33, fill(8'h55), 1, 1'b1);
        read_all("rd_after_illegal");

        // reset during second EXEC beat of a scalar multiply
        write_vec(0, ramp(1, 1));
        issue(4'b0110, 0, 0, 1, 8'h02, 64'h0);
        tick();
        reset_i = 1'b1;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk_i);
            check("abort_no_done", {62'b0, done_w, done_s}, 64'b0);
        end
        tick();
        reset_i = 1'b0;
        @(negedge clk_i);
        check("abort_no_done_after", {62'b0, done_w, done_s}, 64'b0);
        check("abort_ready", {62'b0, ready_w, ready_s}, 64'b11);
        check("abort_rdata", rdata_w | rdata_s, 64'h0);
        for (int i = 0; i < 8; i++) begin mem_w[i] = '0; mem_s[i] = '0; end
        read_all("rd_after_reset");

        check("exp_q_w_empty", 64'(exp_w_q.size()), 64'd0);
        check("exp_q_s_empty", 64'(exp_s_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/vector_exec_unit.md
VECTOR_EXEC_UNIT -- requirements
Module: vector_exec_unit

Interface
REQ-001 The block SHALL have parameter els_p, default 8, meaning the number of vectors held in the internal register file.
REQ-002 The block SHALL have parameter vlen_p, default 8, meaning the number of elements per vector.
REQ-003 The block SHALL have parameter vdw_p, default 8, meaning the bits per element (signed two's complement).
REQ-004 The block SHALL have parameter lanes_p, default 4, meaning the elements processed per cycle; vlen_p % lanes_p == 0 is required, and a violation is an elaboration error.
REQ-005 The block SHALL have parameter sat_p, default 0, meaning arithmetic mode: 0 = wrap, 1 = signed saturate.
REQ-006 Ports, one per line (name, direction, width, meaning):
  clk_i  in  1  sole clock
  reset_i  in  1  synchronous, active-high reset
  v_i  in  1  request valid
  ready_o  out  1  request accepted when v_i & ready_o
  op_i  in  4  opcode
  addrA_i / addrB_i / addrD_i  in  clog2(els_p) each  operand A, operand B, destination
  scalar_i  in  vdw_p  scalar operand
  w_data_i  in  vlen_p*vdw_p  write data; element k is at bits [k*vdw_p +: vdw_p]
  r_data_o  out  vlen_p*vdw_p  response data
  v_o  out  1  response valid
  yumi_i  in  1  response consumed
  done_o  out  1  one-cycle retire pulse
  err_o  out  1  one-cycle illegal-opcode pulse

Function
REQ-007 Opcodes SHALL be:
  - 0000 D=A+B
  - 0001 D=A-B
  - 0010 D=A*B
  - 0100 D=A+s
  - 0101 D=A-s
  - 0110 D=A*s
  - 1000 read A
  - 1001 write D=w_data_i
  - 1010 reduce-sum of A
  - all other codes illegal.
REQ-008 The register file SHALL be els_p x vlen_p x vdw_p flops, internal to the block.
REQ-009 The FSM SHALL have states IDLE, EXEC, DONE and RESP.
REQ-010 ready_o SHALL be 1 only in IDLE.
REQ-011 On v_i & ready_o, the block SHALL latch op, addresses, scalar and w_data, clear the beat counter, and go to EXEC.
REQ-012 In EXEC, each cycle SHALL process elements beat*lanes_p through beat*lanes_p+lanes_p-1, reading A/B from the register file and writing D at the clock edge for write-type ops (0000–0110, 1001).
REQ-013 EXEC SHALL last exactly B = vlen_p/lanes_p cycles; the beat counter SHALL then wrap to 0.
REQ-014 After the last beat, ops 1000 and 1010 SHALL go to RESP; all others SHALL go to DONE.
REQ-015 DONE SHALL last exactly one cycle, with done_o=1, then go to IDLE; ready_o SHALL return B+2 cycles after acceptance.
REQ-016 In RESP, v_o SHALL be 1 and r_data_o held stable until yumi_i; on yumi_i, done_o=1 and the next state is IDLE.
REQ-017 A new request SHALL NOT be accepted in the same cycle as yumi_i.
REQ-018 Read: r_data_o SHALL equal vector A, assembled beat by beat.
REQ-019 Reduce: r_data_o[vdw_p-1:0] SHALL equal the sum of all A elements, with the accumulator at vdw_p bits; upper bits SHALL be zero.
REQ-020 In wrap mode, results SHALL be the low vdw_p bits of the exact result; for multiply, the low vdw_p bits of the signed product.
REQ-021 In sat mode, each add, sub or mul result, and each reduce accumulation step, SHALL clamp to [-2^(vdw_p-1), 2^(vdw_p-1)-1].
REQ-022 When D aliases A or B, results SHALL be correct, since each beat reads and writes only its own elements.
REQ-023 An illegal opcode SHALL be accepted, SHALL modify no state, and SHALL go directly to DONE with err_o=1 and done_o=1 in that cycle.
REQ-024 r_data_o SHALL be zero in IDLE, EXEC and DONE, and SHALL be cleared on the exit from RESP.
REQ-025 v_i is ignored when ready_o=0, and yumi_i is ignored outside RESP.

Reset
REQ-026 reset_i SHALL take the block to IDLE and SHALL clear the beat counter, the register file and all latched fields.
REQ-027 Output reset values SHALL be: ready_o=1, v_o=0, done_o=0, err_o=0, r_data_o=0.
REQ-028 reset_i asserted in any state, including mid-EXEC or in RESP, SHALL abort the operation with no done_o; the state after reset SHALL equal the state after power-up reset.

Verification (vlen_p=8, lanes_p=4, vdw_p=8)
REQ-029 Write v0=1..8 and v1=all 10, then op 0000 A=0 B=1 D=2, then read v2 -> r_data_o elements 11..18; done_o on cycle 3 after acceptance; ready_o back on cycle 4.
REQ-030 sat_p=1: v0=all 100, op 0000 A=0 B=0 D=3, read v3 -> all 127; the same sequence with sat_p=0 -> all -56.
REQ-031 v0=1..8, op 1010 A=0 -> r_data_o low byte 36, upper bits 0; with v0=all 100 and sat_p=1 -> 127.
REQ-032 Read with yumi_i held low for 5 cycles -> v_o stays 1 and r_data_o stays stable; yumi_i pulse -> done_o=1 for one cycle, then ready_o=1.
REQ-033 Opcode 0111 -> err_o and done_o pulse together one cycle after acceptance, and a subsequent read of all vectors shows them unchanged.
REQ-034 Write v0=1..8, then assert reset_i during the second EXEC beat of op 0110 with s=2 -> all reads return 0, and no done_o fires for the aborted op.
